// File: rtl/uart_pkg.sv
// Shared constants for the UART command responder.
// Holds the command/reply byte values and the 3-bit FSM state codes.
package uart_pkg;

  localparam logic [7:0] CMD_PING = 8'h50;
  localparam logic [7:0] CMD_RAND = 8'h52;
  localparam logic [7:0] RSP_OK   = 8'h4B;
  localparam logic [7:0] RSP_ERR  = 8'h3F;

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_GET_CNT   = 3'd1;
  localparam logic [2:0] S_LOAD      = 3'd2;
  localparam logic [2:0] S_ISSUE     = 3'd3;
  localparam logic [2:0] S_WAIT_DONE = 3'd4;
  localparam logic [2:0] S_RELEASE   = 3'd5;

  // Where the next reply byte comes from.
  typedef enum logic {SRC_REG = 1'b0, SRC_FIFO = 1'b1} src_t;

endpackage

// File: rtl/byte_fifo.sv
// First-word-fall-through byte FIFO that buffers TRNG output.
// The head byte is visible on o_dout whenever o_empty is low.
module byte_fifo #(
  parameter int DEPTH = 16
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_push,
  input  logic [7:0] i_din,
  input  logic       i_pop,
  output logic [7:0] o_dout,
  output logic       o_full,
  output logic       o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign do_push = i_push && !o_full;
  assign do_pop  = i_pop && !o_empty;
  assign o_full  = (count == (AW+1)'(DEPTH));
  assign o_empty = (count == '0);
  assign o_dout  = mem[rd_ptr];

  // Storage needs no reset; only the pointers define what is valid.
  always_ff @(posedge i_clk) begin
    if (do_push) mem[wr_ptr] <= i_din;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_cmd_responder.sv
// Decodes host command bytes from the UART receiver and streams replies to the
// transmitter one byte at a time; random bytes come from a TRNG-fed FIFO.
module uart_cmd_responder
  import uart_pkg::*;
#(
  parameter int FIFO_DEPTH  = 16,
  parameter int CMD_TIMEOUT = 43500
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_RX_DV,
  input  logic [7:0] i_RX_Byte,
  input  logic       i_rnd_valid,
  input  logic [7:0] i_rnd_byte,
  output logic       o_rnd_ready,
  output logic       o_TX_DV,
  output logic [7:0] o_TX_Byte,
  input  logic       i_TX_Active,
  input  logic       i_TX_Done,
  output logic       o_busy,
  output logic       o_err
);

  localparam int            TW           = $clog2(CMD_TIMEOUT);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(CMD_TIMEOUT - 1);

  logic [2:0]    state, state_next;
  logic [7:0]    reply_reg, reply_next;
  logic [8:0]    remaining, remaining_next;
  src_t          src, src_next;
  logic [TW-1:0] timer, timer_next;
  logic [7:0]    tx_byte_next;
  logic          tx_dv_next;
  logic          err_next;
  logic          fifo_pop;
  logic          fifo_full;
  logic          fifo_empty;
  logic [7:0]    fifo_dout;

  byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_push  (i_rnd_valid),
    .i_din   (i_rnd_byte),
    .i_pop   (fifo_pop),
    .o_dout  (fifo_dout),
    .o_full  (fifo_full),
    .o_empty (fifo_empty)
  );

  assign o_rnd_ready = !fifo_full;
  assign o_busy      = (state != S_IDLE);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state     <= S_IDLE;
      reply_reg <= 8'h00;
      remaining <= 9'd0;
      src       <= SRC_REG;
      timer     <= '0;
      o_TX_Byte <= 8'h00;
      o_TX_DV   <= 1'b0;
      o_err     <= 1'b0;
    end else begin
      state     <= state_next;
      reply_reg <= reply_next;
      remaining <= remaining_next;
      src       <= src_next;
      timer     <= timer_next;
      o_TX_Byte <= tx_byte_next;
      o_TX_DV   <= tx_dv_next;
      o_err     <= err_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:      if (i_RX_DV) state_next = (i_RX_Byte == CMD_RAND) ? S_GET_CNT : S_LOAD;
      S_GET_CNT: begin
        if (i_RX_DV)                    state_next = S_LOAD;
        else if (timer == TIMEOUT_LAST) state_next = S_IDLE;
      end
      S_LOAD:      if (src == SRC_REG || !fifo_empty) state_next = S_ISSUE;
      // Never hand a byte to a transmitter that is still finishing a frame.
      S_ISSUE:     if (!i_TX_Active && !i_TX_Done) state_next = S_WAIT_DONE;
      S_WAIT_DONE: if (i_TX_Done) state_next = S_RELEASE;
      S_RELEASE:   if (!i_TX_Done) state_next = (remaining == 9'd0) ? S_IDLE : S_LOAD;
      default:     state_next = S_IDLE;
    endcase
  end

  always_comb begin
    reply_next     = reply_reg;
    remaining_next = remaining;
    src_next       = src;
    timer_next     = timer;
    tx_byte_next   = o_TX_Byte;
    tx_dv_next     = 1'b0;
    err_next       = 1'b0;
    fifo_pop       = 1'b0;
    case (state)
      S_IDLE: begin
        if (i_RX_DV) begin
          if (i_RX_Byte == CMD_RAND) begin
            timer_next = '0;
          end else begin
            reply_next     = (i_RX_Byte == CMD_PING) ? RSP_OK : RSP_ERR;
            err_next       = (i_RX_Byte != CMD_PING);
            remaining_next = 9'd1;
            src_next       = SRC_REG;
          end
        end
      end
      S_GET_CNT: begin
        // A count byte of zero requests a full 256-byte burst.
        if (i_RX_DV) begin
          remaining_next = (i_RX_Byte == 8'h00) ? 9'd256 : {1'b0, i_RX_Byte};
          src_next       = SRC_FIFO;
        end else if (timer == TIMEOUT_LAST) begin
          err_next = 1'b1;
        end else begin
          timer_next = timer + 1'b1;
        end
      end
      S_LOAD: begin
        if (src == SRC_REG) begin
          tx_byte_next = reply_reg;
        end else if (!fifo_empty) begin
          tx_byte_next = fifo_dout;
          fifo_pop     = 1'b1;
        end
      end
      S_ISSUE: begin
        if (!i_TX_Active && !i_TX_Done) begin
          tx_dv_next     = 1'b1;
          remaining_next = remaining - 9'd1;
        end
      end
      default: ;
    endcase
    if (i_RX_DV && state != S_IDLE && state != S_GET_CNT) err_next = 1'b1;
  end

endmodule
